// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value 0..F.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg.sv
// Combinational nibble-to-segment decoder for a common-anode display.
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; every nibble value has an entry.
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches a 16-bit value and scans it as four hex digits onto a multiplexed
// common-anode 7-segment display, with a blank cycle between digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV  = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int              PW      = $clog2(CLK_DIV);
    localparam int              IW      = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_DIV - 1);

    logic [15:0]   shadow;
    logic [PW-1:0] prescaler;
    logic [IW-1:0] idx;
    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    digit_seg;
    logic          digit_blank;

    assign dp = 1'b1;

    // Tick marks the last cycle of a digit slot; it only exists while scanning.
    always_comb begin
        tick   = en && (prescaler == PRE_MAX);
        nibble = shadow[{idx, 2'b00} +: 4];
    end

    // A non-zero digit position is dark when it and every higher nibble are zero.
    always_comb begin
        digit_blank = 1'b0;
        if (BLANK_LZ) begin
            case (idx)
                2'd1:    digit_blank = (shadow[15:4]  == 12'h000);
                2'd2:    digit_blank = (shadow[15:8]  == 8'h00);
                2'd3:    digit_blank = (shadow[15:12] == 4'h0);
                default: digit_blank = 1'b0;
            endcase
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (digit_seg)
    );

    // Shadow register captures the display value on load, even while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= 16'h0000;
        end else if (load) begin
            shadow <= value;
        end
    end

    // Prescaler and digit index advance only while enabled, freezing otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (en) begin
            if (tick) begin
                prescaler <= '0;
                idx       <= idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Registered outputs: dark when disabled, anodes off on the slot's last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (!en) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (tick) begin
            an  <= AN_OFF;
        end else begin
            an  <= digit_blank ? AN_OFF : ~(4'b0001 << idx);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with CLK_DIV=4; one instance without and
// one with leading-zero blanking, both driven by the same stimulus.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SX = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        en;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    int totalCount = 0;
    int passCount  = 0;

    seg7_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1'b0)) u0 (
        .clk(clk), .rst(rst), .load(load), .value(value), .en(en),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    seg7_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1'b1)) u1 (
        .clk(clk), .rst(rst), .load(load), .value(value), .en(en),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic [15:0] v);
        rst   = r;
        load  = l;
        en    = e;
        value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Lit cycles of one slot followed by its blank cycle (seg holds on u0).
    task automatic runSlot(input string tag, input int lit, input logic [15:0] v,
                           input logic [3:0] expAn0, input logic [6:0] expSeg0,
                           input logic [3:0] expAn1, input logic [6:0] expSeg1);
        for (int i = 0; i < lit; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, v);
            checkOutput({tag, " lit u0"}, {5'h0, an0, seg0}, {5'h0, expAn0, expSeg0});
            if (expAn1 != 4'b1111)
                checkOutput({tag, " lit u1"}, {5'h0, an1, seg1}, {5'h0, expAn1, expSeg1});
            else
                checkOutput({tag, " lz u1"}, {12'h0, an1}, {12'h0, 4'b1111});
        end
        applyStimulus(1'b0, 1'b0, 1'b1, v);
        checkOutput({tag, " blank u0"}, {5'h0, an0, seg0}, {5'h0, 4'b1111, expSeg0});
        checkOutput({tag, " blank u1"}, {12'h0, an1}, {12'h0, 4'b1111});
    endtask

    initial begin
        // Reset held three cycles with a competing load.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
            checkOutput("reset u0", {4'h0, dp0, an0, seg0}, {4'h0, 1'b1, 4'b1111, SX});
            checkOutput("reset u1", {4'h0, dp1, an1, seg1}, {4'h0, 1'b1, 4'b1111, SX});
        end

        // First edge after release shows digit 0 of the cleared shadow.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
        checkOutput("release d0", {5'h0, an0, seg0}, {5'h0, 4'b1110, S0});

        // Load A5C3: this edge still shows the old shadow.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hA5C3);
        checkOutput("load edge", {5'h0, an0, seg0}, {5'h0, 4'b1110, S0});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hA5C3);
        checkOutput("load latency", {5'h0, an0, seg0}, {5'h0, 4'b1110, S3});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hA5C3);
        checkOutput("slot0 blank", {5'h0, an0, seg0}, {5'h0, 4'b1111, S3});
        runSlot("A5C3 d1", 3, 16'hA5C3, 4'b1101, SC, 4'b1101, SC);
        runSlot("A5C3 d2", 3, 16'hA5C3, 4'b1011, S5, 4'b1011, S5);
        runSlot("A5C3 d3", 3, 16'hA5C3, 4'b0111, SA, 4'b0111, SA);
        runSlot("A5C3 d0", 3, 16'hA5C3, 4'b1110, S3, 4'b1110, S3);

        // Load 0042 at the start of digit 1's slot.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0042);
        checkOutput("0042 load u0", {5'h0, an0, seg0}, {5'h0, 4'b1101, SC});
        runSlot("0042 d1", 2, 16'h0042, 4'b1101, S4, 4'b1101, S4);
        runSlot("0042 d2", 3, 16'h0042, 4'b1011, S0, 4'b1111, S0);
        runSlot("0042 d3", 3, 16'h0042, 4'b0111, S0, 4'b1111, S0);
        runSlot("0042 d0", 3, 16'h0042, 4'b1110, S2, 4'b1110, S2);

        // Load 0000: only digit 0 stays lit with blanking.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
        checkOutput("0000 load u1", {5'h0, an1, seg1}, {5'h0, 4'b1101, S4});
        runSlot("0000 d1", 2, 16'h0000, 4'b1101, S0, 4'b1111, S0);
        runSlot("0000 d2", 3, 16'h0000, 4'b1011, S0, 4'b1111, S0);
        runSlot("0000 d3", 3, 16'h0000, 4'b0111, S0, 4'b1111, S0);
        runSlot("0000 d0", 3, 16'h0000, 4'b1110, S0, 4'b1110, S0);

        // Load 1111 at digit 1, then load 2222 on the tick cycle.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111);
        checkOutput("1111 load u1", {12'h0, an1}, {12'h0, 4'b1111});
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h1111);
            checkOutput("1111 d1", {5'h0, an0, seg0}, {5'h0, 4'b1101, S1});
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h2222);
        checkOutput("tick load blank", {5'h0, an0, seg0}, {5'h0, 4'b1111, S1});
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222);
        checkOutput("tick load d2 u0", {5'h0, an0, seg0}, {5'h0, 4'b1011, S2});
        checkOutput("tick load d2 u1", {5'h0, an1, seg1}, {5'h0, 4'b1011, S2});

        // Disable for ten cycles mid-slot of digit 2.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h2222);
            checkOutput("en off u0", {5'h0, an0, seg0}, {5'h0, 4'b1111, SX});
            checkOutput("en off u1", {5'h0, an1, seg1}, {5'h0, 4'b1111, SX});
        end
        runSlot("resume d2", 2, 16'h2222, 4'b1011, S2, 4'b1011, S2);

        // Reset mid-scan at digit 3.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222);
        checkOutput("pre-reset d3", {5'h0, an0, seg0}, {5'h0, 4'b0111, S2});
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h2222);
        checkOutput("mid reset", {4'h0, dp0, an0, seg0}, {4'h0, 1'b1, 4'b1111, SX});
        runSlot("restart d0", 3, 16'h2222, 4'b1110, S0, 4'b1110, S0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222);
        checkOutput("restart d1 u0", {5'h0, an0, seg0}, {5'h0, 4'b1101, S0});
        checkOutput("restart d1 u1", {12'h0, an1}, {12'h0, 4'b1111});

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side counterpart of the board's button input conditioning.
- Takes a 16-bit result from the multiplier datapath and shows it as 4 hex digits on the board's multiplexed common-anode 7-segment display.
- Latches the value on a load strobe, then scans the digits with a clock prescaler.
- Inserts a one-cycle anode blank at each digit change to suppress ghosting.
- Optionally blanks leading zeros.

Parameters:
- CLK_DIV, 100000, clocks per digit slot (100 MHz clk gives a 1 kHz digit rate); legal range >= 2.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- load  in  1  one-cycle strobe; capture value into the shadow register
- value  in  16  hex value to display; digit k = value[4k+3:4k]
- en  in  1  display enable; 0 blanks the display and freezes the scan
- an  out  4  anode selects, active-low; an[k] drives digit k
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low; always 1 (off)

Behaviour:
- Reset (rst=1 at posedge clk):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1.
  - Internal state: shadow=16'h0000, prescaler=0, idx=0.
  - Reset overrides load and en in the same cycle.
- Shadow register:
  - On posedge with load=1, shadow<=value.
  - Outputs reflect the new shadow on the following edge (1-cycle latency), in the current digit slot.
  - load while en=0 still captures.
- Prescaler:
  - When en=1, counts 0..CLK_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where prescaler==CLK_DIV-1.
  - On tick, idx<=idx+1 mod 4 (3 wraps to 0).
  - When en=0, prescaler and idx hold their values.
- Output register (all outputs registered, no combinational path from inputs):
  - en=0: an<=4'b1111, seg<=7'b1111111.
  - en=1 and tick: an<=4'b1111 (ghost blank); seg holds.
  - en=1, no tick: an<=~(4'b0001<<idx) and seg<=hex_to_seg(shadow nibble idx), subject to leading-zero blanking.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k>=1) is blanked (an forced to 1111 for its slot) when shadow[15:4k]==0.
  - Digit 0 is always shown, so 16'h0000 displays "0".
- Slot timing: after reset release with en=1, digit 0 drives from the first edge. Each slot has CLK_DIV-1 lit cycles followed by 1 blank cycle.
- Simultaneous load and tick: both take effect. The blank cycle occurs, then the next digit uses the new shadow.
- en deasserted mid-slot: blank on the next edge. On reassert, scanning resumes at the held idx and prescaler.
- Hex encoding (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package seg7_pkg holds:
  - NUM_DIGITS=4
  - SEG_BLANK=7'b1111111
  - AN_OFF=4'b1111
  - the 16-entry hex-to-segment constant table
- One combinational sub-module, hex_to_seg: 4-bit nibble in, 7-bit active-low pattern out, table from the package.
- Prescaler, idx counter, shadow register, blanking logic and output registers stay in the top block.

Test Plan (CLK_DIV=4 for simulation):
- Reset held 3 cycles with load=1 and value=16'h1234 -> an=1111, seg=1111111, dp=1 throughout; after release with en=1, first edge gives an=1110, seg=1000000 (shadow is 0).
- load with value=16'hA5C3, en=1, BLANK_LZ=0 -> one cycle later seg=0110000 on an=1110. The sequence of lit digits is 3, C, 5, A, then wraps to 3. Each digit is lit 3 cycles followed by 1 cycle of an=1111.
- BLANK_LZ=1, value=16'h0042 -> digit0 "2" (0100100) and digit1 "4" (0011001) are lit; digit2 and digit3 slots show an=1111; value=16'h0000 lights only digit0 "0".
- load pulse coincident with tick while digit1 is showing 16'h1111, new value=16'h2222 -> the blank cycle occurs, then digit2 shows 0100100.
- en dropped for 10 cycles mid-slot of digit2 -> an=1111 from the next edge; idx and prescaler are frozen; after reassert, digit2 completes its remaining slot count.
- rst asserted mid-scan at idx=3 -> next edge gives an=1111, shadow=0; after release the scan restarts at digit0 with prescaler=0.
